// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and write-back types for the register-file write-port arbiter.
package regfile_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [1:0] {WB_NONE, WB_PRIMARY, WB_LONG} wb_src_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] wd;
    } wb_req_t;
endpackage

// File: rtl/regfile_lq_fifo.sv
// regfile_lq_fifo: synchronous FIFO buffering long-latency results until the write port is free.
module regfile_lq_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between pipeline writeback and a
// long-latency unit, tracking outstanding long destinations and stalling decode on them.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH   = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = regfile_pkg::ADDR_WIDTH,
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p_we,
    input  logic [ADDR_WIDTH-1:0]    p_rd,
    input  logic [DATA_WIDTH-1:0]    p_wd,
    input  logic                     l_valid,
    output logic                     l_ready,
    input  logic [ADDR_WIDTH-1:0]    l_rd,
    input  logic [DATA_WIDTH-1:0]    l_wd,
    input  logic                     iss_valid,
    input  logic [ADDR_WIDTH-1:0]    iss_rd,
    input  logic                     dec_valid,
    input  logic [ADDR_WIDTH-1:0]    rs1,
    input  logic [ADDR_WIDTH-1:0]    rs2,
    input  logic [ADDR_WIDTH-1:0]    dec_rd,
    output logic                     stall,
    output logic                     wb_hold,
    output logic                     WE3,
    output logic [ADDR_WIDTH-1:0]    AD3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic [2**ADDR_WIDTH-1:0] busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_src_e                          sel;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0]            head_rd;
    logic [DATA_WIDTH-1:0]            head_wd;
    logic                             full, empty, push, from_long;
    logic [$clog2(LQ_DEPTH):0]        count;
    logic [CW-1:0]                    starve, starve_next;
    logic [2**ADDR_WIDTH-1:0]         busy_next;

    assign l_ready = !full && !rst;
    // x0 results are consumed from the long unit but never occupy a FIFO slot
    assign push    = l_valid && l_ready && l_rd != '0;
    assign head_rd = head[DATA_WIDTH +: ADDR_WIDTH];
    assign head_wd = head[DATA_WIDTH-1:0];
    assign stall   = dec_valid && (busy[rs1] || busy[rs2] || busy[dec_rd]);

    regfile_lq_fifo #(
        .WIDTH(ADDR_WIDTH + DATA_WIDTH),
        .DEPTH(LQ_DEPTH)
    ) u_lq (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(sel == WB_LONG),
        .wdata({l_rd, l_wd}),
        .rdata(head),
        .full(full),
        .empty(empty),
        .count(count)
    );

    always_comb begin
        sel = (wb_hold && !empty) ? WB_LONG :
              (p_we && p_rd != '0) ? WB_PRIMARY :
              !empty ? WB_LONG : WB_NONE;
        starve_next = (count == '0 || sel == WB_LONG) ? '0 :
                      (sel == WB_PRIMARY && starve != CW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
    end

    // a FIFO commit clears its busy bit at the same edge the register file is written; a new issue wins
    always_comb begin
        busy_next = busy;
        if (WE3 && from_long) busy_next[AD3] = 1'b0;
        if (iss_valid && iss_rd != '0) busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WE3       <= 1'b0;
            AD3       <= '0;
            WD3       <= '0;
            from_long <= 1'b0;
            busy      <= '0;
            starve    <= '0;
            wb_hold   <= 1'b0;
        end else begin
            WE3       <= sel != WB_NONE;
            AD3       <= sel == WB_LONG ? head_rd : sel == WB_PRIMARY ? p_rd : '0;
            WD3       <= sel == WB_LONG ? head_wd : sel == WB_PRIMARY ? p_wd : '0;
            from_long <= sel == WB_LONG;
            busy      <= busy_next;
            starve    <= starve_next;
            wb_hold   <= starve_next == CW'(STARVE_LIMIT);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write-port scoreboard and a reference model
// of the FIFO, scoreboard and starvation counter.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst, p_we, l_valid, iss_valid, dec_valid;
    logic [AW-1:0] p_rd, l_rd, iss_rd, rs1, rs2, dec_rd;
    logic [DW-1:0] p_wd, l_wd;
    logic l_ready, stall, wb_hold, WE3;
    logic [AW-1:0] AD3;
    logic [DW-1:0] WD3;
    logic [2**AW-1:0] busy;

    exp_t exp_q[$];
    exp_t mq[$];
    int checks = 0;
    int failures = 0;
    int mcnt = 0;
    bit mhold = 1'b0;
    bit mlast_long = 1'b0;
    logic [AW-1:0] mlast_rd = '0;
    logic [2**AW-1:0] mbusy = '0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_rd(p_rd), .p_wd(p_wd),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_wd(l_wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .dec_valid(dec_valid), .rs1(rs1), .rs2(rs2), .dec_rd(dec_rd),
        .stall(stall), .wb_hold(wb_hold),
        .WE3(WE3), .AD3(AD3), .WD3(WD3), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model the edge from the current inputs, queue the expected write, then compare after the edge.
    task automatic tick();
        exp_t e;
        logic [2**AW-1:0] nb;
        bit acc, lng, prm, emp;
        e = '0;
        nb = mbusy;
        lng = 1'b0;
        if (mlast_long) nb[mlast_rd] = 1'b0;
        if (rst) begin
            mq.delete();
            mcnt = 0;
            mhold = 1'b0;
            nb = '0;
        end else begin
            emp = mq.size() == 0;
            acc = l_valid && mq.size() < DEPTH;
            lng = !emp && (mhold || !(p_we && p_rd != 0));
            prm = !lng && p_we && p_rd != 0;
            chk("iss_to_busy", 64'(iss_valid && iss_rd != 0 && mbusy[iss_rd] && !(mlast_long && mlast_rd == iss_rd)), 0);
            chk("pwe_to_busy", 64'(p_we && p_rd != 0 && mbusy[p_rd]), 0);
            chk("pwe_on_hold", 64'(p_we && mhold), 0);
            chk("long_not_busy", 64'(acc && l_rd != 0 && !mbusy[l_rd]), 0);
            if (lng) e = mq.pop_front();
            else if (prm) e = {1'b1, p_rd, p_wd};
            if (acc && l_rd != 0) mq.push_back({1'b1, l_rd, l_wd});
            mcnt = (emp || lng) ? 0 : (prm && mcnt < LIMIT) ? mcnt + 1 : mcnt;
            mhold = mcnt == LIMIT;
            if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
        end
        nb[0] = 1'b0;
        mlast_long = lng;
        mlast_rd = e.rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        mbusy = nb;
        e = exp_q.pop_front();
        chk("write_port", 64'({WE3, AD3, WD3}), 64'(e));
        chk("busy", 64'(busy), 64'(mbusy));
        chk("wb_hold", 64'(wb_hold), 64'(mhold));
        chk("l_ready", 64'(l_ready), 64'(!rst && mq.size() < DEPTH));
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        iss_valid = 1'b1;
        iss_rd = rd;
        tick();
        iss_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; p_we = 0; p_rd = 0; p_wd = 0; l_valid = 1'b1; l_rd = 0; l_wd = 0;
        iss_valid = 0; iss_rd = 0; dec_valid = 0; rs1 = 0; rs2 = 0; dec_rd = 0;
        repeat (3) tick();
        chk("rst_we3", 64'(WE3), 0);
        chk("rst_l_ready", 64'(l_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        rst = 1'b0;
        l_valid = 1'b0;
        #1;
        chk("ready_after_rst", 64'(l_ready), 1);

        p_we = 1'b1; p_rd = 5; p_wd = 32'hDEADBEEF;
        tick();
        chk("prim_write", 64'({WE3, AD3, WD3}), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
        p_rd = 0;
        tick();
        chk("prim_x0", 64'(WE3), 0);
        p_we = 1'b0;

        issue(7);
        chk("busy7_set", 64'(busy[7]), 1);
        dec_valid = 1'b1; rs1 = 1; rs2 = 7; dec_rd = 2;
        #1;
        chk("stall_rs2", 64'(stall), 1);
        l_valid = 1'b1; l_rd = 7; l_wd = 32'h1234;
        tick();
        l_valid = 1'b0;
        chk("long_no_bypass", 64'(WE3), 0);
        tick();
        chk("long_write", 64'({WE3, AD3, WD3}), 64'({1'b1, 5'd7, 32'h1234}));
        chk("stall_until_commit", 64'(stall), 1);
        tick();
        chk("busy7_clear", 64'(busy[7]), 0);
        chk("stall_drop", 64'(stall), 0);
        dec_valid = 1'b0;

        iss_valid = 1'b1; iss_rd = 0; l_valid = 1'b1; l_rd = 0; l_wd = 32'hBAD;
        tick();
        iss_valid = 1'b0; l_valid = 1'b0;
        tick();
        chk("long_x0", 64'(WE3), 0);
        chk("busy0", 64'(busy[0]), 0);

        issue(9);
        l_valid = 1'b1; l_rd = 9; l_wd = 32'h99;
        tick();
        l_valid = 1'b0;
        p_we = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            p_rd = 5'(10 + i);
            p_wd = 32'(160 + i);
            tick();
            chk("hold_rise", 64'(wb_hold), 64'(i == LIMIT - 1));
        end
        p_we = 1'b0;
        tick();
        chk("starved_write", 64'({WE3, AD3, WD3}), 64'({1'b1, 5'd9, 32'h99}));
        chk("hold_clear", 64'(wb_hold), 0);

        issue(11); issue(12); issue(13);
        p_we = 1'b1; p_rd = 20; p_wd = 32'h20; l_valid = 1'b1; l_rd = 11; l_wd = 32'h11;
        tick();
        p_rd = 21; p_wd = 32'h21; l_rd = 12; l_wd = 32'h12;
        tick();
        chk("full_not_ready", 64'(l_ready), 0);
        p_rd = 22; p_wd = 32'h22; l_rd = 13; l_wd = 32'h13;
        tick();
        chk("held_not_ready", 64'(l_ready), 0);
        p_we = 1'b0;
        tick();
        chk("pop_11", 64'({WE3, AD3}), 64'({1'b1, 5'd11}));
        chk("ready_after_pop", 64'(l_ready), 1);
        tick();
        l_valid = 1'b0;
        chk("pop_12", 64'({WE3, AD3}), 64'({1'b1, 5'd12}));
        tick();
        chk("held_not_lost", 64'({WE3, AD3, WD3}), 64'({1'b1, 5'd13, 32'h13}));
        tick();
        chk("full_busy_clear", 64'(busy[13:11]), 0);

        issue(3);
        l_valid = 1'b1; l_rd = 3; l_wd = 32'h33;
        tick();
        l_valid = 1'b0;
        tick();
        chk("x3_commit", 64'({WE3, AD3}), 64'({1'b1, 5'd3}));
        issue(3);
        chk("set_wins", 64'(busy[3]), 1);

        l_valid = 1'b1; l_rd = 3; l_wd = 32'h77;
        tick();
        l_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_busy", 64'(busy), 0);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_fifo_dropped", 64'(WE3), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
